// File: rtl/pdp8_iot_pkg.sv
// Shared constants, TX state type and IOT decode helper for the PDP-8/I
// negative-bus character device responder.
package pdp8_iot_pkg;

    localparam logic [2:0] IOT_OPCODE = 3'b110;

    // Field positions in PDP bit numbering (bit 0 is the MSB).
    localparam int OP_MSB   = 0;
    localparam int OP_LSB   = 2;
    localparam int DEV_MSB  = 3;
    localparam int DEV_LSB  = 8;
    localparam int DATA_MSB = 4;
    localparam int DATA_LSB = 11;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_state_e;

    function automatic logic iot_hit(input logic [0:11] mb, input logic [5:0] code);
        return (mb[OP_MSB:OP_LSB] == IOT_OPCODE) && (mb[DEV_MSB:DEV_LSB] == code);
    endfunction

endpackage

// File: rtl/iop_sync.sv
// Two-flop synchronizer plus rising-edge detector for one BIOP line.
module iop_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic iop,
    output logic level,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= iop;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/iot_char_responder.sv
// PDP-8/I negative I/O bus responder for a two-code character device:
// KSF/KCC/KRS on DEV_CODE, TSF/TCF/TPC on DEV_CODE+1.
module iot_char_responder
    import pdp8_iot_pkg::*;
#(
    parameter logic [5:0] DEV_CODE = 6'o03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:11] bmb,
    input  logic [0:11] bac,
    input  logic        biop1,
    input  logic        biop2,
    input  logic        biop4,
    output logic [0:11] io_data,
    output logic        io_skip,
    output logic        io_ac_clear,
    output logic        int_rq,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [5:0] OUT_CODE = DEV_CODE + 6'd1;

    logic lvl1, lvl2, lvl4;
    logic rise1, rise2, rise4;

    iop_sync u_sync1 (.clk(clk), .rst_n(rst_n), .iop(biop1), .level(lvl1), .rise(rise1));
    iop_sync u_sync2 (.clk(clk), .rst_n(rst_n), .iop(biop2), .level(lvl2), .rise(rise2));
    iop_sync u_sync4 (.clk(clk), .rst_n(rst_n), .iop(biop4), .level(lvl4), .rise(rise4));

    logic in_hit, out_hit;
    logic ksf, kcc, krs, tsf, tcf, tpc;

    assign in_hit  = iot_hit(bmb, DEV_CODE);
    assign out_hit = iot_hit(bmb, OUT_CODE);

    assign ksf = rise1 & in_hit;
    assign kcc = rise2 & in_hit;
    assign krs = rise4 & in_hit;
    assign tsf = rise1 & out_hit;
    assign tcf = rise2 & out_hit;
    assign tpc = rise4 & out_hit;

    logic unused_fields;
    assign unused_fields = ^{bmb[9:11], bac[0:3]};

    // ---------------- receive side ----------------
    logic       rx_flag;
    logic [7:0] rx_buf;
    logic       rx_take;

    // Holding ready low during KCC keeps a simultaneous byte for the next cycle.
    assign rx_ready = ~rx_flag & ~kcc;
    assign rx_take  = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_flag <= 1'b0;
            rx_buf  <= 8'h00;
        end else if (kcc) begin
            rx_flag <= 1'b0;
        end else if (rx_take) begin
            rx_flag <= 1'b1;
            rx_buf  <= rx_data;
        end
    end

    // ---------------- bus responses ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_skip     <= 1'b0;
            io_ac_clear <= 1'b0;
            io_data     <= 12'o0000;
        end else begin
            if (ksf)
                io_skip <= rx_flag;
            else if (tsf)
                io_skip <= tx_flag;
            else if (!lvl1)
                io_skip <= 1'b0;

            if (kcc)
                io_ac_clear <= 1'b1;
            else if (!lvl2)
                io_ac_clear <= 1'b0;

            if (krs)
                io_data <= {4'b0000, rx_buf};
            else if (!lvl4)
                io_data <= 12'o0000;
        end
    end

    // ---------------- transmit side ----------------
    tx_state_e  state, state_nxt;
    logic       tx_flag;
    logic [7:0] tx_buf;
    logic       tpc_go;
    logic       tpc_p1;
    logic       done_p1;

    // TPC only loads when the transmitter is idle and no start is pending.
    assign tpc_go = tpc & (state == IDLE) & ~tpc_p1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (tpc_p1)
                    state_nxt = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tpc_p1  <= 1'b0;
            done_p1 <= 1'b0;
            tx_buf  <= 8'h00;
            tx_flag <= 1'b0;
        end else begin
            tpc_p1  <= tpc_go;
            done_p1 <= (state == DONE);
            if (tpc_go)
                tx_buf <= bac[DATA_MSB:DATA_LSB];
            // Completion set has priority over a coincident TCF.
            if (done_p1)
                tx_flag <= 1'b1;
            else if (tcf)
                tx_flag <= 1'b0;
        end
    end

    assign tx_data = tx_buf;
    assign int_rq  = rx_flag | tx_flag;

endmodule

// File: tb/tb_iot_char_responder.sv
// Directed bench for iot_char_responder: reset, RX/KSF, KCC/KRS, TX handshake,
// ignored IOTs, simultaneous KCC with rx_valid, reset during SEND.
module tb_iot_char_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:11] bmb = 12'o0000;
    logic [0:11] bac = 12'o0000;
    logic        biop1 = 1'b0, biop2 = 1'b0, biop4 = 1'b0;
    logic [0:11] io_data;
    logic        io_skip, io_ac_clear, int_rq;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    iot_char_responder #(.DEV_CODE(6'o03)) dut (
        .clk(clk), .rst_n(rst_n), .bmb(bmb), .bac(bac),
        .biop1(biop1), .biop2(biop2), .biop4(biop4),
        .io_data(io_data), .io_skip(io_skip), .io_ac_clear(io_ac_clear), .int_rq(int_rq),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        step(3);
        n_checks++; if (io_data !== 12'o0000) begin n_fail++; $display("FAIL rst_io_data: got %o want 0000", io_data); end
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL rst_io_skip: got %b want 0", io_skip); end
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL rst_ac_clear: got %b want 0", io_ac_clear); end
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL rst_int_rq: got %b want 0", int_rq); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_rx_skip;
        rx_data = 8'hC1; rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
        n_checks++; if (int_rq !== 1'b1) begin n_fail++; $display("FAIL rx_int_rq: got %b want 1", int_rq); end
        bmb = 12'o6031; biop1 = 1'b1;
        step(2);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL ksf_t1: got %b want 0", io_skip); end
        step(1);
        n_checks++; if (io_skip !== 1'b1) begin n_fail++; $display("FAIL ksf_t2: got %b want 1", io_skip); end
        step(1);
        n_checks++; if (io_skip !== 1'b1) begin n_fail++; $display("FAIL ksf_hold: got %b want 1", io_skip); end
        biop1 = 1'b0;
        step(2);
        n_checks++; if (io_skip !== 1'b1) begin n_fail++; $display("FAIL ksf_hold_fall: got %b want 1", io_skip); end
        step(1);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL ksf_release: got %b want 0", io_skip); end
        step(2);
    endtask

    task automatic test_read_clear;
        bmb = 12'o6036; biop2 = 1'b1;
        step(2);
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL kcc_t1: got %b want 0", io_ac_clear); end
        step(1);
        n_checks++; if (io_ac_clear !== 1'b1) begin n_fail++; $display("FAIL kcc_t2: got %b want 1", io_ac_clear); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL kcc_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL kcc_int_rq: got %b want 0", int_rq); end
        biop2 = 1'b0;
        step(3);
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL kcc_release: got %b want 0", io_ac_clear); end
        biop4 = 1'b1;
        step(3);
        n_checks++; if (io_data !== 12'o0301) begin n_fail++; $display("FAIL krs_data: got %o want 0301", io_data); end
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL krs_no_clear: got %b want 0", io_ac_clear); end
        biop4 = 1'b0;
        step(3);
        n_checks++; if (io_data !== 12'o0000) begin n_fail++; $display("FAIL krs_release: got %o want 0000", io_data); end
        bmb = 12'o6031; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL ksf_empty: got %b want 0", io_skip); end
        biop1 = 1'b0;
        step(3);
    endtask

    task automatic test_tx_handshake;
        tx_ready = 1'b0; bac = 12'o0101; bmb = 12'o6044; biop4 = 1'b1;
        step(3);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tpc_t2: got %b want 0", tx_valid); end
        step(1);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tpc_t3: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tpc_data: got %h want 41", tx_data); end
        biop4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_stall[%0d]: got %b want 1", i, tx_valid); end
        end
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_after_hs: got %b want 0", tx_valid); end
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL txflag_h0: got %b want 0", int_rq); end
        step(1);
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL txflag_h1: got %b want 0", int_rq); end
        step(1);
        n_checks++; if (int_rq !== 1'b1) begin n_fail++; $display("FAIL txflag_h2: got %b want 1", int_rq); end
        bmb = 12'o6041; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b1) begin n_fail++; $display("FAIL tsf_skip: got %b want 1", io_skip); end
        biop1 = 1'b0;
        step(3);
    endtask

    task automatic test_ignored;
        bmb = 12'o6042; biop2 = 1'b1;
        step(3);
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL tcf_no_clear: got %b want 0", io_ac_clear); end
        biop2 = 1'b0;
        step(3);
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL tcf_flag: got %b want 0", int_rq); end
        bac = 12'o0102; bmb = 12'o6044; biop4 = 1'b1;
        step(4);
        n_checks++; if (tx_data !== 8'h42) begin n_fail++; $display("FAIL tpc2_data: got %h want 42", tx_data); end
        biop4 = 1'b0;
        step(3);
        bac = 12'o0177; biop4 = 1'b1;
        step(4);
        n_checks++; if (tx_data !== 8'h42) begin n_fail++; $display("FAIL tpc_in_send: got %h want 42", tx_data); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL send_kept: got %b want 1", tx_valid); end
        biop4 = 1'b0;
        step(3);
        rx_data = 8'h5A; rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        bmb = 12'o6051; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL dev05_skip: got %b want 0", io_skip); end
        biop1 = 1'b0;
        step(3);
        biop4 = 1'b1;
        step(3);
        n_checks++; if (io_data !== 12'o0000) begin n_fail++; $display("FAIL dev05_data: got %o want 0000", io_data); end
        biop4 = 1'b0;
        step(3);
        biop2 = 1'b1;
        step(3);
        n_checks++; if (io_ac_clear !== 1'b0) begin n_fail++; $display("FAIL dev05_clear: got %b want 0", io_ac_clear); end
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL dev05_rxflag: got %b want 0", rx_ready); end
        biop2 = 1'b0;
        step(3);
        bmb = 12'o5031; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL non_iot_skip: got %b want 0", io_skip); end
        biop1 = 1'b0;
        step(3);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx2_done: got %b want 0", tx_valid); end
        step(2);
    endtask

    task automatic test_kcc_rx;
        bmb = 12'o6036; rx_data = 8'h3C; rx_valid = 1'b1; biop2 = 1'b1;
        step(2);
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL kccrx_t1: got %b want 0", rx_ready); end
        step(1);
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL kccrx_t2: got %b want 1", rx_ready); end
        n_checks++; if (io_ac_clear !== 1'b1) begin n_fail++; $display("FAIL kccrx_clear: got %b want 1", io_ac_clear); end
        step(1);
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL kccrx_take: got %b want 0", rx_ready); end
        rx_valid = 1'b0; biop2 = 1'b0;
        step(3);
        biop4 = 1'b1;
        step(3);
        n_checks++; if (io_data !== 12'o0074) begin n_fail++; $display("FAIL kccrx_data: got %o want 0074", io_data); end
        biop4 = 1'b0;
        step(3);
        bmb = 12'o6031; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b1) begin n_fail++; $display("FAIL kccrx_skip: got %b want 1", io_skip); end
        biop1 = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid_send;
        tx_ready = 1'b0; bac = 12'o0125; bmb = 12'o6044; biop4 = 1'b1;
        step(4);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rsend_valid: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL rsend_data: got %h want 55", tx_data); end
        biop4 = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(1);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rsend_abort: got %b want 0", tx_valid); end
        n_checks++; if (int_rq !== 1'b0) begin n_fail++; $display("FAIL rsend_int_rq: got %b want 0", int_rq); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rsend_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rsend_tx_buf: got %h want 00", tx_data); end
        rst_n = 1'b1; tx_ready = 1'b1;
        step(3);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rsend_idle: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        bmb = 12'o6041; biop1 = 1'b1;
        step(3);
        n_checks++; if (io_skip !== 1'b0) begin n_fail++; $display("FAIL rsend_tsf: got %b want 0", io_skip); end
        biop1 = 1'b0;
        step(3);
    endtask

    initial begin
        test_reset();
        test_rx_skip();
        test_read_clear();
        test_tx_handshake();
        test_ignored();
        test_kcc_rx();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_char_responder.md
# iot_char_responder

Peripheral-side responder for the PDP-8/I negative I/O bus, the receiving end of the bus driven by the processor's power amplifiers. It decodes IOT instructions from the buffered memory buffer (BMB) and BIOP1/2/4 pulses for a two-code character device. It returns skip, AC-clear and input data to the processor, and exchanges bytes with a device-side core over ready/valid handshakes. The block sits between the bus-receiver gates and a character peripheral such as a serial line.

## Interface
- `DEV_CODE`, 6'o03: input device code. The output device code is `DEV_CODE+1`, modulo 64.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `bmb` in [0:11]: buffered MB. Bit 0 is the MSB, using PDP numbering.
- `bac` in [0:11]: buffered AC.
- `biop1`, `biop2`, `biop4` in 1 each: IOP pulses, active high after the receivers. Asynchronous to `clk`. Each pulse is at least 3 clk wide.
- `io_data` out [0:11]: data to the AC input lines. It is 0 when not enabled.
- `io_skip` out 1: skip request.
- `io_ac_clear` out 1: AC clear request.
- `int_rq` out 1: interrupt request, equal to `rx_flag | tx_flag`.
- `rx_data` in 8: inbound byte from the device core.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the responder can accept a byte.
- `tx_data` out 8: outbound byte to the device core.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the device core accepts the byte.

## Operation
- **IOT match:** `bmb[0:2]==3'b110`, and `bmb[3:8]` equals `DEV_CODE` (input side, "IN") or `DEV_CODE+1` (output side, "OUT"). `bmb` is sampled in the cycle the IOP edge is detected.
- **IN, IOP1 (KSF):** `io_skip = rx_flag`.
- **IN, IOP2 (KCC):** `io_ac_clear = 1`. `rx_flag` clears.
- **IN, IOP4 (KRS):** `io_data[4:11] = rx_buf`. `io_data[0:3] = 0`.
- **OUT, IOP1 (TSF):** `io_skip = tx_flag`.
- **OUT, IOP2 (TCF):** `tx_flag` clears.
- **OUT, IOP4 (TPC):** `tx_buf` is loaded from `bac[4:11]` and the TX FSM starts.
- **RX path:**
  - `rx_ready = !rx_flag`.
  - On `rx_valid & rx_ready`, `rx_buf` is loaded from `rx_data` and `rx_flag` is set.
  - While the flag is set there is no overrun; the core is held off.
- **TX FSM:**
  - IDLE: on TPC, go to SEND.
  - SEND: `tx_valid = 1` and `tx_data = tx_buf`. On `tx_ready`, go to DONE.
  - DONE: set `tx_flag`, then go to IDLE. DONE lasts one cycle.
  - TPC in SEND or DONE is ignored. `tx_buf` is not modified.
- **Reset values:**
  - `io_data = 0`, `io_skip = 0`, `io_ac_clear = 0`, `int_rq = 0`, `tx_valid = 0`.
  - `rx_ready = 1`, since `rx_flag = 0` and `tx_flag = 0`.
  - `rx_buf = 0`, `tx_buf = 0`, FSM in IDLE.
- **Reset mid-operation:** reset aborts a transfer in SEND. `tx_valid` is 0 at the first edge with `rst_n` low, and the byte is lost.
- **Simultaneous events:**
  - KCC in the same cycle as `rx_valid`: the clear wins. `rx_ready` is low that cycle, and the byte is accepted the next cycle.
  - TCF in the same cycle as DONE: the set wins, and `tx_flag` ends at 1.
- **Decode gating:** non-matching device codes and non-IOT opcodes produce no response, and all outputs stay at 0.

## Timing
- **Synchronization:** each `biopN` passes through a 2-flop synchronizer and then a rising-edge detector. Take T as the first `clk` edge that samples `biopN` high:
  - the synchronized level is high after edge T+1;
  - the edge is detected in the cycle after T+1;
  - actions are registered at edge T+2.
- **Level outputs:** `io_skip`, `io_ac_clear` and `io_data` are valid from edge T+2. They hold until the edge after the synchronized IOP is seen low, which is 2 edges after `biopN` falls.
- **Flag and buffer updates:** flag clears and TPC loads occur once, at edge T+2.
- **TX latency:** `tx_valid` rises at edge T+3. After the `tx_ready` handshake edge, `tx_flag` is set 2 edges later.
- **IOP overlap:** consecutive IOP1/2/4 pulses do not overlap. Each pulse is handled independently.

## Structure
- **Package `pdp8_iot_pkg`:**
  - `IOT_OPCODE` = 3'b110;
  - the TX FSM state enum `{IDLE, SEND, DONE}`;
  - the bit-slice constants for the device field `[3:8]` and the data field `[4:11]`.
- **Sub-module `iop_sync`:** 2-flop synchronizer plus rising-edge detector, with outputs `level` and `rise`. It is instantiated three times, once per IOP line.

## Test plan
- **RX and skip:** with DEV_CODE=03, push `rx_data=8'hC1`, then issue `bmb=12'o6031` with IOP1. Required: `io_skip=1` from T+2; `rx_ready=0`; `int_rq=1`.
- **Read and clear:** issue `bmb=12'o6036`, with IOP2 followed by IOP4. Required: `io_ac_clear` pulses during IOP2; `io_data=12'o0301` during IOP4; `rx_flag=0` afterward; `rx_ready=1`.
- **TX handshake:** `bac=12'o0101`, issue `bmb=12'o6044` with IOP4, and hold `tx_ready` low for 5 cycles. Required: `tx_data=8'h41`; `tx_valid` stays high through the stall; `tx_flag` is set 2 edges after `tx_ready`; TSF (`12'o6041`) then skips.
- **Ignored IOTs:** issue TPC while in SEND, then an IOT with device 05. Required: `tx_buf` unchanged; all outputs 0 for device 05.
- **Simultaneous KCC and rx_valid:** `rx_ready` is low that cycle, and the byte is accepted one cycle later with `rx_flag=1`.
- **Reset mid-send:** assert `rst_n` low in SEND. Required: `tx_valid=0` at the next edge; all flags 0; FSM in IDLE.
